// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/ready bus between the memory-stage controller (master)
// and the data memory (slave).
interface mem_stage_ctrl_if;
    logic        dm_req;
    logic        dm_we;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic [15:0] dm_rdata;
    logic        dm_ready;

    modport master (
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_rdata, dm_ready
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_rdata, dm_ready
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: runs load/store/push/pop over a request/ready bus and owns the SP.
// Optional stack bounds checking is enabled by defining MEM_STAGE_SP_BOUNDS_EN.
module mem_stage_ctrl #(
    parameter logic [15:0] SP_INIT  = 16'hFFFE,
    parameter logic [15:0] SP_LIMIT = 16'hF800
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [15:0]             alu_result,
    input  logic [15:0]             rs_data,
    input  logic [15:0]             rd_data,
    input  logic [2:0]              rd,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    reg_write,
    output logic                    stall_o,
    mem_stage_ctrl_if.master        dm,
    output logic                    wb_valid,
    output logic [15:0]             wb_data,
    output logic [2:0]              wb_rd,
    output logic                    wb_reg_write,
    output logic                    err_o,
    output logic [15:0]             sp_o,
    output logic                    sp_fault_o
);

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_e;

    typedef enum logic [1:0] {
        OP_LOAD,
        OP_STORE,
        OP_PUSH,
        OP_POP
    } op_e;

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [2:0]  acc_rd_q, acc_rd_d;
    logic [15:0] sp_q, sp_d;
    logic        sp_fault_q, sp_fault_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        wb_valid_q, wb_valid_d;
    logic [15:0] wb_data_q, wb_data_d;
    logic [2:0]  wb_rd_q, wb_rd_d;
    logic        wb_reg_write_q, wb_reg_write_d;
    logic        err_q, err_d;

    logic        illegal;
    logic        mem_op;
    logic        bound_hit;

    assign illegal = $countones({mem_read, mem_write, push, pop}) > 1;
    assign mem_op  = mem_read | mem_write | push | pop;

`ifdef MEM_STAGE_SP_BOUNDS_EN
    assign bound_hit = (push && sp_q == SP_LIMIT) || (pop && sp_q == SP_INIT);
`else
    logic sp_limit_unused;
    assign sp_limit_unused = ^SP_LIMIT;
    assign bound_hit       = 1'b0;
`endif

    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        acc_rd_d       = acc_rd_q;
        sp_d           = sp_q;
        sp_fault_d     = sp_fault_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        we_d           = we_q;
        wb_valid_d     = 1'b0;
        wb_data_d      = wb_data_q;
        wb_rd_d        = wb_rd_q;
        wb_reg_write_d = 1'b0;
        err_d          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (illegal) begin
                        err_d      = 1'b1;
                        wb_valid_d = 1'b1;
                        wb_data_d  = alu_result;
                        wb_rd_d    = rd;
                    end else if (!mem_op || bound_hit) begin
                        // Plain ALU ops and suppressed stack ops retire in one cycle.
                        wb_valid_d     = 1'b1;
                        wb_data_d      = alu_result;
                        wb_rd_d        = rd;
                        wb_reg_write_d = reg_write && !mem_op;
                        sp_fault_d     = sp_fault_q | bound_hit;
                    end else begin
                        state_d  = S_ACCESS;
                        acc_rd_d = rd;
                        if (mem_read) begin
                            op_d   = OP_LOAD;
                            addr_d = alu_result;
                            we_d   = 1'b0;
                        end else if (mem_write) begin
                            op_d    = OP_STORE;
                            addr_d  = alu_result;
                            we_d    = 1'b1;
                            wdata_d = rs_data;
                        end else if (push) begin
                            op_d    = OP_PUSH;
                            addr_d  = sp_q;
                            we_d    = 1'b1;
                            wdata_d = rd_data;
                        end else begin
                            op_d   = OP_POP;
                            addr_d = sp_q + 16'd1;
                            we_d   = 1'b0;
                        end
                    end
                end
            end

            S_ACCESS: begin
                if (dm.dm_ready) begin
                    state_d        = S_IDLE;
                    we_d           = 1'b0;
                    wb_valid_d     = 1'b1;
                    wb_rd_d        = acc_rd_q;
                    wb_reg_write_d = (op_q == OP_LOAD) || (op_q == OP_POP);
                    wb_data_d      = wb_reg_write_d ? dm.dm_rdata : addr_q;
                    if (op_q == OP_PUSH) sp_d = sp_q - 16'd1;
                    if (op_q == OP_POP)  sp_d = sp_q + 16'd1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            op_q           <= OP_LOAD;
            acc_rd_q       <= 3'd0;
            sp_q           <= SP_INIT;
            sp_fault_q     <= 1'b0;
            addr_q         <= 16'd0;
            wdata_q        <= 16'd0;
            we_q           <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_data_q      <= 16'd0;
            wb_rd_q        <= 3'd0;
            wb_reg_write_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            acc_rd_q       <= acc_rd_d;
            sp_q           <= sp_d;
            sp_fault_q     <= sp_fault_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            we_q           <= we_d;
            wb_valid_q     <= wb_valid_d;
            wb_data_q      <= wb_data_d;
            wb_rd_q        <= wb_rd_d;
            wb_reg_write_q <= wb_reg_write_d;
            err_q          <= err_d;
        end
    end

    // Request follows the state register directly so reset drops it without a clock.
    assign stall_o      = (state_q == S_ACCESS);
    assign dm.dm_req    = (state_q == S_ACCESS);
    assign dm.dm_we     = we_q;
    assign dm.dm_addr   = addr_q;
    assign dm.dm_wdata  = wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_data      = wb_data_q;
    assign wb_rd        = wb_rd_q;
    assign wb_reg_write = wb_reg_write_q;
    assign err_o        = err_q;
    assign sp_o         = sp_q;
    assign sp_fault_o   = sp_fault_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl with a 16-word memory model.
// Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] alu_result, rs_data, rd_data;
    logic [2:0]  rd;
    logic        mem_read, mem_write, push, pop, reg_write;
    logic        stall_o, wb_valid, wb_reg_write, err_o, sp_fault_o;
    logic [15:0] wb_data, sp_o;
    logic [2:0]  wb_rd;

    logic [15:0] mem_model [16];
    logic [15:0] last_waddr, last_wdata;

    int n_checks = 0;
    int n_pass   = 0;

    mem_stage_ctrl_if mif ();

    mem_stage_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .alu_result   (alu_result),
        .rs_data      (rs_data),
        .rd_data      (rd_data),
        .rd           (rd),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .push         (push),
        .pop          (pop),
        .reg_write    (reg_write),
        .stall_o      (stall_o),
        .dm           (mif.master),
        .wb_valid     (wb_valid),
        .wb_data      (wb_data),
        .wb_rd        (wb_rd),
        .wb_reg_write (wb_reg_write),
        .err_o        (err_o),
        .sp_o         (sp_o),
        .sp_fault_o   (sp_fault_o)
    );

    always #5 clk = ~clk;

    always_comb mif.dm_rdata = mem_model[mif.dm_addr[3:0]];

    always @(posedge clk) begin
        if (mif.dm_req && mif.dm_ready && mif.dm_we) begin
            mem_model[mif.dm_addr[3:0]] <= mif.dm_wdata;
            last_waddr <= mif.dm_addr;
            last_wdata <= mif.dm_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clear_ctrl();
        in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        push = 1'b0; pop = 1'b0; reg_write = 1'b0;
    endtask

    // Presents one instruction for a single rising edge; returns 1ns after that edge.
    task automatic issue(input logic [3:0] ops, input logic rw, input logic [15:0] alu,
                         input logic [15:0] rs, input logic [15:0] rdd, input logic [2:0] dst);
        @(negedge clk);
        {mem_read, mem_write, push, pop} = ops;
        reg_write = rw; alu_result = alu; rs_data = rs; rd_data = rdd; rd = dst;
        in_valid = 1'b1;
        @(posedge clk); #1;
        clear_ctrl();
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem_model[i] = 16'h0000;
        last_waddr = 16'h0; last_wdata = 16'h0;
        clear_ctrl();
        alu_result = 16'h0; rs_data = 16'h0; rd_data = 16'h0; rd = 3'd0;
        mif.dm_ready = 1'b0;
        rst_n = 1'b0;
        #12;
        check("rst_stall",    stall_o,      0);
        check("rst_req",      mif.dm_req,   0);
        check("rst_we",       mif.dm_we,    0);
        check("rst_addr",     mif.dm_addr,  0);
        check("rst_wb_valid", wb_valid,     0);
        check("rst_err",      err_o,        0);
        check("rst_sp",       sp_o,         16'hFFFE);
        check("rst_fault",    sp_fault_o,   0);
        @(negedge clk); rst_n = 1'b1;

        // Non-memory op
        issue(4'b0000, 1'b1, 16'h1234, 16'h0, 16'h0, 3'd5);
        check("alu_wb_valid", wb_valid,     1);
        check("alu_wb_data",  wb_data,      16'h1234);
        check("alu_wb_rd",    wb_rd,        5);
        check("alu_wb_rw",    wb_reg_write, 1);
        check("alu_stall",    stall_o,      0);
        next_cycle();
        check("alu_pulse_end", wb_valid,    0);

        // Store with three wait cycles; an in_valid during ACCESS must be ignored
        issue(4'b0100, 1'b0, 16'h0010, 16'hBEEF, 16'h0, 3'd1);
        for (int c = 0; c < 4; c++) begin
            check("st_req",   mif.dm_req,   1);
            check("st_we",    mif.dm_we,    1);
            check("st_addr",  mif.dm_addr,  16'h0010);
            check("st_wdata", mif.dm_wdata, 16'hBEEF);
            check("st_stall", stall_o,      1);
            check("st_no_wb", wb_valid,     0);
            if (c == 1) begin
                @(negedge clk);
                in_valid = 1'b1; reg_write = 1'b1; alu_result = 16'h5555; rd = 3'd3;
                @(posedge clk); #1;
                clear_ctrl();
            end else if (c < 3) begin
                next_cycle();
            end
        end
        @(negedge clk); mif.dm_ready = 1'b1;
        next_cycle();
        check("st_wb_valid", wb_valid,     1);
        check("st_wb_rw",    wb_reg_write, 0);
        check("st_stall_end", stall_o,     0);
        check("st_req_end",  mif.dm_req,   0);
        check("st_mem",      mem_model[0], 16'hBEEF);

        // Load back the stored word with dm_ready tied high
        issue(4'b1000, 1'b1, 16'h0010, 16'h0, 16'h0, 3'd6);
        check("ld_req",  mif.dm_req, 1);
        check("ld_we",   mif.dm_we,  0);
        next_cycle();
        check("ld_wb_valid", wb_valid,     1);
        check("ld_wb_data",  wb_data,      16'hBEEF);
        check("ld_wb_rd",    wb_rd,        6);
        check("ld_wb_rw",    wb_reg_write, 1);

        // Push then pop
        issue(4'b0010, 1'b0, 16'h0, 16'h0, 16'hAAAA, 3'd0);
        check("push_addr",  mif.dm_addr,  16'hFFFE);
        check("push_we",    mif.dm_we,    1);
        check("push_wdata", mif.dm_wdata, 16'hAAAA);
        next_cycle();
        check("push_wb_rw", wb_reg_write, 0);
        check("push_sp",    sp_o,         16'hFFFD);
        check("push_waddr", last_waddr,   16'hFFFE);
        check("push_wdat",  last_wdata,   16'hAAAA);
        issue(4'b0001, 1'b1, 16'h0, 16'h0, 16'h0, 3'd2);
        check("pop_addr", mif.dm_addr, 16'hFFFE);
        check("pop_we",   mif.dm_we,   0);
        next_cycle();
        check("pop_wb_valid", wb_valid,     1);
        check("pop_wb_data",  wb_data,      16'hAAAA);
        check("pop_wb_rd",    wb_rd,        2);
        check("pop_wb_rw",    wb_reg_write, 1);
        check("pop_sp",       sp_o,         16'hFFFE);

        // Illegal combination
        issue(4'b1010, 1'b1, 16'h0, 16'h0, 16'h0, 3'd4);
        check("ill_err",   err_o,        1);
        check("ill_wb",    wb_valid,     1);
        check("ill_rw",    wb_reg_write, 0);
        check("ill_req",   mif.dm_req,   0);
        check("ill_sp",    sp_o,         16'hFFFE);
        next_cycle();
        check("ill_err_end", err_o, 0);

        // Reset during an access
        issue(4'b0010, 1'b0, 16'h0, 16'h0, 16'h1111, 3'd0);
        next_cycle();
        check("pre_rst_sp", sp_o, 16'hFFFD);
        @(negedge clk); mif.dm_ready = 1'b0;
        issue(4'b1000, 1'b1, 16'h0020, 16'h0, 16'h0, 3'd1);
        check("acc_req", mif.dm_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req",   mif.dm_req, 0);
        check("arst_stall", stall_o,    0);
        check("arst_sp",    sp_o,       16'hFFFE);
        @(negedge clk); mif.dm_ready = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            check("arst_no_wb", wb_valid, 0);
        end

        // Pop from the empty-stack position
        issue(4'b0001, 1'b1, 16'h0, 16'h0, 16'h0, 3'd7);
`ifdef MEM_STAGE_SP_BOUNDS_EN
        check("bpop_req",   mif.dm_req,   0);
        check("bpop_wb",    wb_valid,     1);
        check("bpop_rw",    wb_reg_write, 0);
        check("bpop_fault", sp_fault_o,   1);
        check("bpop_sp",    sp_o,         16'hFFFE);
        next_cycle();
        next_cycle();
        check("bpop_sticky", sp_fault_o,  1);
`else
        check("wpop_req",  mif.dm_req,  1);
        check("wpop_addr", mif.dm_addr, 16'hFFFF);
        next_cycle();
        check("wpop_wb",    wb_valid,   1);
        check("wpop_sp",    sp_o,       16'hFFFF);
        check("wpop_fault", sp_fault_o, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller of the five-stage pipeline. It consumes the control and data fields latched by the execute/memory pipeline register, runs loads, stores, pushes and pops against the data memory over a request/ready handshake, and owns the stack pointer. It stalls the upstream pipeline while an access is outstanding and presents one registered result per instruction to the memory/write-back register.

## Interface
Parameters:
- SP_INIT, 16'hFFFE: stack pointer value after reset; the empty-stack position.
- SP_LIMIT, 16'hF800: lowest legal stack address. Used only with the bounds feature.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction present from the execute/memory register.
- alu_result  in  16  effective address for a load or store.
- rs_data  in  16  store data.
- rd_data  in  16  push data.
- rd  in  3  destination register.
- mem_read, mem_write, push, pop, reg_write  in  1 each  operation controls.
- stall_o  out  1  upstream must hold its outputs and not advance.
- dm_req  out  1  memory request.
- dm_we  out  1  write enable.
- dm_addr  out  16  memory word address.
- dm_wdata  out  16  write data.
- dm_rdata  in  16  read data; valid when dm_ready=1.
- dm_ready  in  1  access completes at this rising edge.
- wb_valid  out  1  one-cycle result pulse.
- wb_data  out  16  load/pop data, or alu_result for non-memory ops.
- wb_rd  out  3  destination register.
- wb_reg_write  out  1  write-back enable.
- err_o  out  1  one-cycle pulse for an illegal control combination.
- sp_o  out  16  current stack pointer.
- sp_fault_o  out  1  sticky stack bound fault.

## Operation
- States are IDLE and ACCESS. stall_o = (state == ACCESS), decoded combinationally from the state register.
- An instruction is accepted at a rising edge when in_valid=1 and state=IDLE.
- Classification of an accepted instruction:
  - Illegal: more than one of mem_read, mem_write, push, pop set. Result: err_o pulses, no access, wb_valid=1 with wb_reg_write=0, SP unchanged.
  - Non-memory op: wb_data=alu_result, wb_rd=rd, wb_reg_write=reg_write, wb_valid=1. State stays IDLE.
  - Load: dm_addr=alu_result, dm_we=0.
  - Store: dm_addr=alu_result, dm_we=1, dm_wdata=rs_data.
  - Push: dm_addr=SP, dm_we=1, dm_wdata=rd_data.
  - Pop: dm_addr=SP+1, dm_we=0.
- For load, store, push and pop, the access fields are registered and the state goes to ACCESS.
- ACCESS drives dm_req=1. dm_addr, dm_we and dm_wdata stay stable until dm_ready=1 is sampled.
- At the edge where dm_ready=1 is sampled, the block returns to IDLE and produces its result:
  - wb_valid=1.
  - Load/pop: wb_data=dm_rdata.
  - wb_reg_write=1 for load and pop, 0 for store and push.
  - Push: SP←SP−1. Pop: SP←SP+1.
- SP arithmetic is modulo 2^16.
- in_valid is ignored while in ACCESS.
- Reset values: state IDLE, SP=SP_INIT, sp_fault_o=0. dm_req, dm_we, wb_valid, wb_reg_write and err_o are 0. dm_addr, dm_wdata, wb_data and wb_rd are 0.

## Timing
- wb_valid, wb_data, wb_rd, wb_reg_write and err_o are registered, and each pulse lasts exactly one cycle.
- Non-memory op accepted at edge T: result visible after T, valid for one cycle.
- Memory op accepted at edge T: dm_req is high from T. If dm_ready=1 at edge T+1, the result is visible after T+1 (2-cycle latency) and stall_o is high for one cycle.
- Each wait cycle of dm_ready=0 adds one cycle of latency and of stall_o.
- A new instruction can be accepted at the same edge that completes an access only if state is IDLE at that edge. It is not, so the earliest next accept is the following edge.
- dm_ready while state=IDLE is ignored.
- Reset asserted mid-access: dm_req drops immediately, the transaction is abandoned, and there is no writeback.

## Configuration
- MEM_STAGE_SP_BOUNDS_EN defined:
  - A push with SP==SP_LIMIT, or a pop with SP==SP_INIT, is suppressed: no memory request and SP unchanged.
  - The instruction completes as a one-cycle writeback with wb_reg_write=0.
  - sp_fault_o sets and stays set until reset.
- MEM_STAGE_SP_BOUNDS_EN undefined: the SP wraps freely, sp_fault_o is tied 0, and SP_LIMIT is unused.

## Test plan
- Reset, then non-memory op with alu_result=16'h1234, rd=5, reg_write=1 → next cycle wb_valid=1, wb_data=16'h1234, wb_rd=5, wb_reg_write=1; stall_o stays 0.
- Store rs_data=16'hBEEF to 16'h0010 with dm_ready delayed 3 cycles → dm_req/dm_we high for 4 cycles with stable address and data; stall_o high for 4 cycles; then wb_valid=1 with wb_reg_write=0.
- Push rd_data=16'hAAAA, then pop into rd=2, dm_ready tied 1 and memory modelled → write lands at 16'hFFFE, SP goes to 16'hFFFD, pop reads 16'hFFFE, wb_data=16'hAAAA, SP returns to 16'hFFFE.
- mem_read and push both set → err_o pulses once, dm_req stays 0, wb_reg_write=0, SP unchanged.
- rst_n pulsed low while in ACCESS → dm_req falls without waiting for a clock, no wb_valid is produced, SP=SP_INIT.
- With MEM_STAGE_SP_BOUNDS_EN, pop at reset → no dm_req, sp_fault_o=1 and stays 1. Without MEM_STAGE_SP_BOUNDS_EN, the same pop reads 16'hFFFF, SP=16'hFFFF, sp_fault_o=0.
